pipeline_issue_unit: RTL and testbench

PIPELINE_ISSUE_UNIT -- requirements
Module: pipeline_issue_unit

---
 rtl/pipeline_issue_unit.sv | 104 ++++++++++
 tb/tb_pipeline_issue_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issue_unit.sv
// In-order issue stage: FIFO instruction buffer feeding a registered issue slot,
// with a two-deep destination-register history that stalls RAW-dependent heads.
module pipeline_issue_unit #(
   parameter int         DEPTH    = 4,
   parameter logic [3:0] NOP_FUNC = 4'b1111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [50:0] in_instr,
   input  logic        halt,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [3:0]  func,
   output logic [31:0] addr,
   output logic        issue_valid,
   output logic        empty,
   output logic        full,
   output logic [15:0] issued_count,
   output logic [15:0] bubble_count
);

   localparam int         AW        = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [50:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [4:0]    h1;

   logic [50:0] head;
   logic [4:0]  head_rs1;
   logic [4:0]  head_rs2;
   logic        hazard;
   logic        push;
   logic        pop;

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_CNT);
   assign in_ready = !full;

   assign head     = mem[rd_ptr];
   assign head_rs1 = head[50:46];
   assign head_rs2 = head[45:41];

   // The rd output register doubles as H0, the newest history entry.
   assign hazard = ((head_rs1 != 5'd0) && ((head_rs1 == rd) || (head_rs1 == h1))) ||
                   ((head_rs2 != 5'd0) && ((head_rs2 == rd) || (head_rs2 == h1)));

   assign push = in_valid && in_ready;
   assign pop  = !empty && !halt && !hazard;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_instr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         h1           <= 5'd0;
         rs1          <= 5'd0;
         rs2          <= 5'd0;
         rd           <= 5'd0;
         func         <= NOP_FUNC;
         addr         <= 32'd0;
         issue_valid  <= 1'b0;
         issued_count <= 16'd0;
         bubble_count <= 16'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         h1 <= rd;
         if (pop) begin
            rs1         <= head[50:46];
            rs2         <= head[45:41];
            rd          <= head[40:36];
            func        <= head[35:32];
            addr        <= head[31:0];
            issue_valid <= 1'b1;
            if (issued_count != 16'hFFFF) issued_count <= issued_count + 16'd1;
         end else begin
            rs1         <= 5'd0;
            rs2         <= 5'd0;
            rd          <= 5'd0;
            func        <= NOP_FUNC;
            addr        <= 32'd0;
            issue_valid <= 1'b0;
            if (bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_issue_unit.sv
// Directed bench for pipeline_issue_unit: independent issue, RAW stalls,
// fill/overflow with wrap, simultaneous push/pop and asynchronous reset.
module tb_pipeline_issue_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [50:0] in_instr;
   logic        halt;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [3:0]  func;
   logic [31:0] addr;
   logic        issue_valid;
   logic        empty;
   logic        full;
   logic [15:0] issued_count;
   logic [15:0] bubble_count;

   int tests;
   int failed;
   int cyc;
   int iss;

   pipeline_issue_unit #(.DEPTH(4), .NOP_FUNC(4'b1111)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .halt         (halt),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .func         (func),
      .addr         (addr),
      .issue_valid  (issue_valid),
      .empty        (empty),
      .full         (full),
      .issued_count (issued_count),
      .bubble_count (bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [50:0] mk(input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [4:0] d, input logic [3:0] f,
                                      input logic [31:0] a);
      return {s1, s2, d, f, a};
   endfunction

   // One edge; inputs settle before it, outputs are checked 1 time unit after.
   task automatic tick();
      @(posedge clk);
      if (!reset) cyc++;
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".valid"}, 64'(issue_valid), 64'd0);
      chk({tag, ".func"},  64'(func), 64'hF);
      chk({tag, ".regs"},  64'({rs1, rs2, rd}), 64'd0);
      chk({tag, ".addr"},  64'(addr), 64'd0);
   endtask

   task automatic chk_issue(input string tag, input logic [4:0] e_rd, input logic [3:0] e_func);
      chk({tag, ".valid"}, 64'(issue_valid), 64'd1);
      chk({tag, ".rd"},    64'(rd), 64'(e_rd));
      chk({tag, ".func"},  64'(func), 64'(e_func));
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, ".issued"}, 64'(issued_count), 64'(iss));
      chk({tag, ".bubble"}, 64'(bubble_count), 64'(cyc - iss));
   endtask

   initial begin
      tests    = 0;
      failed   = 0;
      cyc      = 0;
      iss      = 0;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      halt     = 1'b0;

      // Reset values are visible before any clock edge
      #1 reset = 1'b1;
      #1;
      chk_bubble("rst0");
      chk("rst0.empty", 64'(empty), 64'd1);
      chk("rst0.full", 64'(full), 64'd0);
      chk("rst0.in_ready", 64'(in_ready), 64'd1);
      chk_counts("rst0");
      tick();
      tick();
      reset = 1'b0;
      cyc   = 0;

      // Independent stream A, B; push into empty issues one edge later
      in_valid = 1'b1;
      in_instr = mk(5'd1, 5'd2, 5'd3, 4'd0, 32'hA);
      tick();
      chk("indep.no_bypass", 64'(issue_valid), 64'd0);
      in_instr = mk(5'd4, 5'd5, 5'd6, 4'd1, 32'hB);
      tick();
      chk_issue("indep.A", 5'd3, 4'd0);
      chk("indep.A.rs", 64'({rs1, rs2}), 64'({5'd1, 5'd2}));
      chk("indep.A.addr", 64'(addr), 64'hA);
      in_valid = 1'b0;
      tick();
      chk_issue("indep.B", 5'd6, 4'd1);
      iss += 2;
      tick();
      chk_bubble("indep.after");
      chk("indep.empty", 64'(empty), 64'd1);
      chk_counts("indep");

      // Back-to-back RAW: A writes r3, B reads r3 -> A, bubble, bubble, B
      halt     = 1'b1;
      in_valid = 1'b1;
      in_instr = mk(5'd1, 5'd2, 5'd3, 4'd0, 32'h1);
      tick();
      in_instr = mk(5'd3, 5'd0, 5'd7, 4'd2, 32'h2);
      tick();
      in_valid = 1'b0;
      halt     = 1'b0;
      tick();
      chk_issue("raw1.A", 5'd3, 4'd0);
      tick();
      chk_bubble("raw1.b1");
      tick();
      chk_bubble("raw1.b2");
      tick();
      chk_issue("raw1.B", 5'd7, 4'd2);
      iss += 2;
      chk_counts("raw1");

      // Distance-2 RAW, then r0 sources behind an r0 producer never stall
      halt     = 1'b1;
      in_valid = 1'b1;
      in_instr = mk(5'd1, 5'd2, 5'd3, 4'd0, 32'h10);
      tick();
      in_instr = mk(5'd4, 5'd5, 5'd6, 4'd1, 32'h11);
      tick();
      in_instr = mk(5'd8, 5'd3, 5'd9, 4'd3, 32'h12);
      tick();
      in_instr = mk(5'd0, 5'd0, 5'd0, 4'd4, 32'h13);
      tick();
      chk("raw2.full", 64'(full), 64'd1);
      chk("raw2.in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      halt     = 1'b0;
      tick();
      chk_issue("raw2.A", 5'd3, 4'd0);
      in_valid = 1'b1;
      in_instr = mk(5'd0, 5'd0, 5'd11, 4'd5, 32'h14);
      tick();
      chk_issue("raw2.C", 5'd6, 4'd1);
      in_valid = 1'b0;
      tick();
      chk_bubble("raw2.b1");
      tick();
      chk_issue("raw2.B", 5'd9, 4'd3);
      tick();
      chk_issue("raw2.E_r0", 5'd0, 4'd4);
      tick();
      chk_issue("raw2.F_r0", 5'd11, 4'd5);
      iss += 5;
      chk_counts("raw2");

      // Fill/overflow with halt, twice, pointers wrapping across 0
      for (int r = 0; r < 2; r++) begin
         halt     = 1'b1;
         in_valid = 1'b1;
         for (int i = 0; i < 5; i++) begin
            in_instr = mk(5'd0, 5'd0, 5'(i + 1), 4'(i), 32'(r * 16 + i));
            tick();
            if (i == 3) chk("fill.full4", 64'(full), 64'd1);
         end
         chk("fill.full5", 64'(full), 64'd1);
         in_valid = 1'b0;
         halt     = 1'b0;
         for (int i = 0; i < 4; i++) begin
            tick();
            chk_issue("fill.drain", 5'(i + 1), 4'(i));
            chk("fill.drain.addr", 64'(addr), 64'(r * 16 + i));
         end
         iss += 4;
         tick();
         chk_bubble("fill.end");
         chk("fill.empty", 64'(empty), 64'd1);
      end
      chk_counts("fill");

      // Simultaneous push/pop at occupancy 2 keeps occupancy at 2
      halt     = 1'b1;
      in_valid = 1'b1;
      in_instr = mk(5'd0, 5'd0, 5'd20, 4'd0, 32'h20);
      tick();
      in_instr = mk(5'd0, 5'd0, 5'd21, 4'd1, 32'h21);
      tick();
      halt     = 1'b0;
      in_instr = mk(5'd0, 5'd0, 5'd22, 4'd2, 32'h22);
      tick();
      chk_issue("pp.X0", 5'd20, 4'd0);
      halt     = 1'b1;
      in_instr = mk(5'd0, 5'd0, 5'd23, 4'd3, 32'h23);
      tick();
      chk("pp.occ3.full", 64'(full), 64'd0);
      in_instr = mk(5'd0, 5'd0, 5'd24, 4'd4, 32'h24);
      tick();
      chk("pp.occ4.full", 64'(full), 64'd1);
      in_valid = 1'b0;
      halt     = 1'b0;
      for (int i = 1; i < 5; i++) begin
         tick();
         chk_issue("pp.drain", 5'(20 + i), 4'(i));
      end
      iss += 5;
      chk_counts("pp");

      // Asynchronous reset with 3 entries still buffered
      halt     = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_instr = mk(5'd0, 5'd0, 5'(i + 1), 4'(i), 32'(i));
         tick();
      end
      in_valid = 1'b0;
      halt     = 1'b0;
      tick();
      chk_issue("arst.pre", 5'd1, 4'd0);
      halt = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk_bubble("arst");
      chk("arst.empty", 64'(empty), 64'd1);
      chk("arst.full", 64'(full), 64'd0);
      chk("arst.in_ready", 64'(in_ready), 64'd1);
      cyc = 0;
      iss = 0;
      chk_counts("arst");
      tick();
      reset = 1'b0;
      halt  = 1'b0;
      tick();
      chk_bubble("arst.post");
      chk("arst.post.empty", 64'(empty), 64'd1);
      chk_counts("arst.post");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
